// File: rtl/recv_ctrl_pkg.sv
// Shared constants for the receiver controller: default history depth,
// pointer/count width helpers and the idle value shown on disp_data.
package recv_ctrl_pkg;

    localparam int DEPTH_DEFAULT = 8;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

    localparam int PTR_W_DEFAULT = ptr_width(DEPTH_DEFAULT);
    localparam int CNT_W_DEFAULT = cnt_width(DEPTH_DEFAULT);

    localparam logic [7:0] DISP_RESET = 8'h00;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a pre-debounced button level: one press pulse
// per low-to-high transition, based on a registered copy of the level.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= level;
    end

    assign press = level & ~prev;

endmodule

// File: rtl/receiver_controller.sv
// Receive history buffer with button browsing and sticky status flags.
// Optional byte echo to the transmitter when RECV_ECHO_EN is defined.
module receiver_controller
    import recv_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    recv_data,
    input  logic                          recv_valid,
    input  logic                          recv_err,
    input  logic                          s3,
    input  logic                          s0,
    input  logic                          s2,
    input  logic                          s1,
    output logic [7:0]                    disp_data,
    output logic [ptr_width(DEPTH)-1:0]   disp_index,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          new_flag,
    output logic                          overflow,
    output logic                          err_flag,
    output logic [7:0]                    echo_data,
    output logic                          echo_enable
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;

    logic [PW-1:0] wr_nx, view_nx;
    logic [CW-1:0] cnt_nx;
    logic          new_nx, ovf_nx, err_nx;

    logic p_older, p_newer, p_ack, p_clr;
    logic accept;

    btn_edge u_s3 (.clk(clk), .rst(rst), .level(s3), .press(p_older));
    btn_edge u_s0 (.clk(clk), .rst(rst), .level(s0), .press(p_newer));
    btn_edge u_s2 (.clk(clk), .rst(rst), .level(s2), .press(p_ack));
    btn_edge u_s1 (.clk(clk), .rst(rst), .level(s1), .press(p_clr));

    assign accept = recv_valid & ~recv_err;

    // Button actions first, then the received byte on top of that result,
    // so a write coinciding with clear/acknowledge lands after it.
    always_comb begin
        wr_nx   = wr_ptr;
        view_nx = disp_index;
        cnt_nx  = count;
        new_nx  = new_flag;
        ovf_nx  = overflow;
        err_nx  = err_flag;

        if (p_clr) begin
            wr_nx   = '0;
            view_nx = '0;
            cnt_nx  = '0;
            new_nx  = 1'b0;
            ovf_nx  = 1'b0;
            err_nx  = 1'b0;
        end else if (p_ack) begin
            view_nx = '0;
            new_nx  = 1'b0;
            ovf_nx  = 1'b0;
            err_nx  = 1'b0;
        end else begin
            if (p_older && !p_newer && (({1'b0, disp_index} + CW'(1)) < count))
                view_nx = disp_index + PW'(1);
            if (p_newer && !p_older && (disp_index != '0))
                view_nx = disp_index - PW'(1);
        end

        wr_idx = wr_nx;

        if (recv_valid && recv_err)
            err_nx = 1'b1;

        if (accept) begin
            wr_nx  = wr_nx + PW'(1);
            new_nx = 1'b1;
            if (cnt_nx == CW'(DEPTH)) ovf_nx = 1'b1;
            else                      cnt_nx = cnt_nx + CW'(1);
            if ((view_nx != '0) && (view_nx != PW'(DEPTH - 1)))
                view_nx = view_nx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            disp_index <= '0;
            count      <= '0;
            new_flag   <= 1'b0;
            overflow   <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            wr_ptr     <= wr_nx;
            disp_index <= view_nx;
            count      <= cnt_nx;
            new_flag   <= new_nx;
            overflow   <= ovf_nx;
            err_flag   <= err_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept)
            mem[wr_idx] <= recv_data;
    end

    assign rd_idx    = wr_ptr - PW'(1) - disp_index;
    assign disp_data = (count == '0) ? DISP_RESET : mem[rd_idx];

`ifdef RECV_ECHO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_data   <= 8'h00;
            echo_enable <= 1'b0;
        end else begin
            echo_enable <= accept;
            if (accept)
                echo_data <= recv_data;
        end
    end
`else
    assign echo_data   = 8'h00;
    assign echo_enable = 1'b0;
`endif

endmodule

// File: tb/tb_receiver_controller.sv
// Self-checking bench for receiver_controller: directed vector table plus
// randomized traffic against a queue-based reference model.
module tb_receiver_controller;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst, recv_valid, recv_err, s3, s0, s2, s1;
    logic [7:0] recv_data;
    logic [7:0] disp_data, echo_data;
    logic [2:0] disp_index;
    logic [3:0] count;
    logic       new_flag, overflow, err_flag, echo_enable;

    receiver_controller #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .recv_data(recv_data), .recv_valid(recv_valid),
        .recv_err(recv_err), .s3(s3), .s0(s0), .s2(s2), .s1(s1),
        .disp_data(disp_data), .disp_index(disp_index), .count(count),
        .new_flag(new_flag), .overflow(overflow), .err_flag(err_flag),
        .echo_data(echo_data), .echo_enable(echo_enable)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: history as a queue, oldest at the front.
    logic [7:0] m_q[$];
    int         m_view;
    logic       m_new, m_ovf, m_err, m_echo_en;
    logic [7:0] m_echo_data;
    logic [3:0] m_prev;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic rv, input logic re, input logic [7:0] d,
                              input logic b3, input logic b0, input logic b2, input logic b1);
        logic k3, k0, k2, k1, acc;
        if (r) begin
            m_q.delete();
            m_view = 0; m_new = 0; m_ovf = 0; m_err = 0;
            m_echo_en = 0; m_echo_data = 8'h00; m_prev = 4'b0000;
            return;
        end
        k3 = b3 && !m_prev[3];
        k0 = b0 && !m_prev[0];
        k2 = b2 && !m_prev[2];
        k1 = b1 && !m_prev[1];
        m_prev = {b3, b2, b1, b0};
        if (k1) begin
            m_q.delete();
            m_view = 0; m_new = 0; m_ovf = 0; m_err = 0;
        end else if (k2) begin
            m_view = 0; m_new = 0; m_ovf = 0; m_err = 0;
        end else if (k3 && !k0) begin
            if (m_view < int'(m_q.size()) - 1) m_view++;
        end else if (k0 && !k3) begin
            if (m_view > 0) m_view--;
        end
        if (rv && re) m_err = 1;
        acc = rv && !re;
        if (acc) begin
            m_q.push_back(d);
            if (m_q.size() > DEPTH) begin
                void'(m_q.pop_front());
                m_ovf = 1;
            end
            m_new = 1;
            if (m_view > 0 && m_view < DEPTH - 1) m_view++;
        end
`ifdef RECV_ECHO_EN
        m_echo_en = acc;
        if (acc) m_echo_data = d;
`else
        m_echo_en = 0;
        m_echo_data = 8'h00;
`endif
    endtask

    function automatic int m_disp();
        if (m_q.size() == 0) return 0;
        return int'(m_q[m_q.size() - 1 - m_view]);
    endfunction

    task automatic check_model();
        chk("model disp_data", int'(disp_data), m_disp());
        chk("model disp_index", int'(disp_index), m_view);
        chk("model count", int'(count), int'(m_q.size()));
        chk("model new_flag", int'(new_flag), int'(m_new));
        chk("model overflow", int'(overflow), int'(m_ovf));
        chk("model err_flag", int'(err_flag), int'(m_err));
        chk("model echo_enable", int'(echo_enable), int'(m_echo_en));
        chk("model echo_data", int'(echo_data), int'(m_echo_data));
    endtask

    task automatic cyc(input logic r, input logic rv, input logic re, input logic [7:0] d,
                       input logic b3, input logic b0, input logic b2, input logic b1);
        rst = r; recv_valid = rv; recv_err = re; recv_data = d;
        s3 = b3; s0 = b0; s2 = b2; s1 = b1;
        @(posedge clk);
        #1;
        model_step(r, rv, re, d, b3, b0, b2, b1);
        check_model();
    endtask

    typedef struct {
        logic       rv, re;
        logic [7:0] d;
        logic       b3, b0, b2, b1;
        int         cnt;
        int         disp;
        int         idx;
        logic       nf, ov, ef;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rv, input logic re, input logic [7:0] d,
                                input logic b3, input logic b0, input logic b2, input logic b1,
                                input int cnt, input int disp, input int idx,
                                input logic nf, input logic ov, input logic ef);
        vec_t v;
        v.rv = rv; v.re = re; v.d = d;
        v.b3 = b3; v.b0 = b0; v.b2 = b2; v.b1 = b1;
        v.cnt = cnt; v.disp = disp; v.idx = idx;
        v.nf = nf; v.ov = ov; v.ef = ef;
        tbl.push_back(v);
    endfunction

    initial begin
        // rv re  d      s3 s0 s2 s1  cnt disp idx nf ov ef
        add(1, 0, 8'h41, 0, 0, 0, 0,  1, 'h41, 0, 1, 0, 0);
        add(1, 0, 8'h42, 0, 0, 0, 0,  2, 'h42, 0, 1, 0, 0);
        add(1, 0, 8'h43, 0, 0, 0, 0,  3, 'h43, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 0,  3, 'h43, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0,  3, 'h43, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0,  3, 'h42, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0,  3, 'h42, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0,  3, 'h42, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0,  3, 'h41, 2, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0,  3, 'h41, 2, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0,  3, 'h41, 2, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0,  3, 'h41, 2, 0, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 0,  3, 'h42, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0,  3, 'h42, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0,  3, 'h42, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0,  3, 'h42, 1, 0, 0, 0);
        add(1, 0, 8'h99, 0, 0, 0, 0,  4, 'h42, 2, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 0,  4, 'h99, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0,  4, 'h99, 0, 0, 0, 0);
        add(1, 1, 8'h55, 0, 0, 0, 0,  4, 'h99, 0, 0, 0, 1);
        add(1, 0, 8'h7E, 0, 0, 0, 1,  1, 'h7E, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0,  1, 'h7E, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 1,  0, 'h00, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0,  0, 'h00, 0, 0, 0, 0);
        for (int k = 0; k <= 8; k++)
            add(1, 0, 8'(k), 0, 0, 0, 0, (k + 1 > 8) ? 8 : k + 1, k, 0, 1, (k == 8), 0);
        for (int v = 1; v <= 7; v++) begin
            add(0, 0, 8'h00, 1, 0, 0, 0, 8, 8 - v, v, 1, 1, 0);
            add(0, 0, 8'h00, 0, 0, 0, 0, 8, 8 - v, v, 1, 1, 0);
        end
        add(0, 0, 8'h00, 1, 0, 0, 0,  8, 'h01, 7, 1, 1, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0,  8, 'h01, 7, 1, 1, 0);
        add(1, 0, 8'h0A, 0, 0, 0, 0,  8, 'h02, 7, 1, 1, 0);

        model_step(1'b1, 0, 0, 8'h00, 0, 0, 0, 0);
        cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
        cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
        chk("reset count", int'(count), 0);
        chk("reset disp_data", int'(disp_data), 0);
        chk("reset disp_index", int'(disp_index), 0);
        chk("reset flags", int'({new_flag, overflow, err_flag}), 0);
        chk("reset echo", int'({echo_enable, echo_data}), 0);

        foreach (tbl[i]) begin
            cyc(0, tbl[i].rv, tbl[i].re, tbl[i].d, tbl[i].b3, tbl[i].b0, tbl[i].b2, tbl[i].b1);
            chk($sformatf("vec%0d count", i), int'(count), tbl[i].cnt);
            chk($sformatf("vec%0d disp_data", i), int'(disp_data), tbl[i].disp);
            chk($sformatf("vec%0d disp_index", i), int'(disp_index), tbl[i].idx);
            chk($sformatf("vec%0d flags", i), int'({new_flag, overflow, err_flag}),
                int'({tbl[i].nf, tbl[i].ov, tbl[i].ef}));
`ifdef RECV_ECHO_EN
            chk($sformatf("vec%0d echo_enable", i), int'(echo_enable), int'(tbl[i].rv && !tbl[i].re));
            if (tbl[i].rv && !tbl[i].re)
                chk($sformatf("vec%0d echo_data", i), int'(echo_data), int'(tbl[i].d));
`else
            chk($sformatf("vec%0d echo tied", i), int'({echo_enable, echo_data}), 0);
`endif
        end

        // Echo pulse must last exactly one cycle after the strobe.
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 0);
        chk("echo single-cycle", int'(echo_enable), 0);

        // Reset coinciding with a strobe drops the byte.
        cyc(1, 1, 0, 8'h33, 0, 0, 0, 0);
        chk("rst drop count", int'(count), 0);
        chk("rst drop echo", int'(echo_enable), 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 0);
        chk("rst drop count after", int'(count), 0);
        chk("rst drop disp", int'(disp_data), 0);

        begin
            logic r, rv, re, b3, b0, b2, b1;
            logic [7:0] d;
            b3 = 0; b0 = 0; b2 = 0; b1 = 0;
            for (int n = 0; n < 3000; n++) begin
                r  = ($urandom_range(0, 299) == 0);
                rv = ($urandom_range(0, 2) == 0);
                re = ($urandom_range(0, 5) == 0);
                d  = 8'($urandom);
                if ($urandom_range(0, 2) == 0) b3 = ~b3;
                if ($urandom_range(0, 2) == 0) b0 = ~b0;
                b2 = ($urandom_range(0, 11) == 0);
                b1 = ($urandom_range(0, 59) == 0);
                cyc(r, rv, re, d, b3, b0, b2, b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
